// File: rtl/timed_event_pkg.sv
// Shared types and default sizes for the timed event scheduler.
package timed_event_pkg;

    localparam int TS_WIDTH_DEF   = 64;
    localparam int DATA_WIDTH_DEF = 128;
    localparam int DEPTH_DEF      = 16;
    localparam int LATE_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/sync_event_fifo.sv
// Single-clock event FIFO with a registered read port; o_rd_data holds the
// last popped entry, which the scheduler uses directly as its head register.
module sync_event_fifo #(
    parameter int WIDTH = 192,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_rd_data;
    assign w_wr      = i_wr_en && !o_full && !i_flush;
    assign w_rd      = i_rd_en && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else if (i_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/timed_event_scheduler.sv
// Queues (timestamp, data) events and releases each payload when the running
// counter reaches its timestamp; late and overflowing events set sticky flags.
module timed_event_scheduler
    import timed_event_pkg::*;
#(
    parameter int TS_WIDTH   = TS_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [TS_WIDTH-1:0]       counter,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TS_WIDTH-1:0]       in_timestamp,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    input  logic                      flush,
    input  logic                      clear_errors,
    output logic                      overflow_error,
    output logic                      late_error,
    output logic [LATE_CNT_WIDTH-1:0] late_count,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int EW = TS_WIDTH + DATA_WIDTH;

    sched_state_t r_state;
    sched_state_t w_next;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_wr;
    logic                      w_overflow;
    logic                      w_pop;
    logic                      w_issue;
    logic                      w_late;
    logic                      w_ack;
    logic [EW-1:0]             w_head;
    logic [TS_WIDTH-1:0]       w_head_ts;
    logic [DATA_WIDTH-1:0]     w_head_data;

    logic                      r_out_valid;
    logic [DATA_WIDTH-1:0]     r_out_data;
    logic                      r_overflow;
    logic                      r_late;
    logic [LATE_CNT_WIDTH-1:0] r_late_count;

    // A write coinciding with flush is dropped silently, so overflow is masked too.
    assign w_wr        = in_valid && !w_full && !flush;
    assign w_overflow  = in_valid &&  w_full && !flush;
    assign w_head_ts   = w_head[EW-1:DATA_WIDTH];
    assign w_head_data = w_head[DATA_WIDTH-1:0];

    sync_event_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_flush   (flush),
        .i_wr_en   (w_wr),
        .i_wr_data ({in_timestamp, in_data}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_pop   = 1'b0;
        w_issue = 1'b0;
        w_late  = 1'b0;
        w_ack   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (counter == w_head_ts) begin
                    w_issue = 1'b1;
                    w_next  = ISSUE;
                end else if (counter > w_head_ts) begin
                    w_late = 1'b1;
                    if (!w_empty) w_pop  = 1'b1;
                    else          w_next = IDLE;
                end
            end
            ISSUE: begin
                if (r_out_valid && out_ready) begin
                    w_ack = 1'b1;
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = WAIT;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        if (flush) begin
            w_next  = IDLE;
            w_pop   = 1'b0;
            w_issue = 1'b0;
            w_late  = 1'b0;
            w_ack   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head_data;
        end else if (w_ack) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky flags: a new error in the same cycle as clear_errors wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow   <= 1'b0;
            r_late       <= 1'b0;
            r_late_count <= '0;
        end else begin
            if (w_overflow)        r_overflow <= 1'b1;
            else if (clear_errors) r_overflow <= 1'b0;

            if (w_late)            r_late <= 1'b1;
            else if (clear_errors) r_late <= 1'b0;

            if (clear_errors)
                r_late_count <= w_late ? LATE_CNT_WIDTH'(1) : '0;
            else if (w_late && (r_late_count != '1))
                r_late_count <= r_late_count + 1'b1;
        end
    end

    assign in_ready       = !w_full;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign overflow_error = r_overflow;
    assign late_error     = r_late;
    assign late_count     = r_late_count;

endmodule

// File: tb/tb_timed_event_scheduler.sv
// Randomized self-checking bench for timed_event_scheduler; expected releases
// and drops come from the timestamp rules applied to the written event list.
module tb_timed_event_scheduler;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [63:0]  counter = 64'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_timestamp = 64'd0;
    logic [127:0] in_data = 128'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         flush = 1'b0;
    logic         clear_errors = 1'b0;
    logic         overflow_error;
    logic         late_error;
    logic [15:0]  late_count;
    logic [4:0]   fifo_count;

    int checks = 0;
    int errors = 0;
    logic cnt_en = 1'b0;
    logic [127:0] acc_q[$];
    logic [63:0]  rise_q[$];
    int stall_break = 0;

    always #5 clk = ~clk;

    timed_event_scheduler dut (
        .clk(clk), .reset_n(reset_n), .counter(counter),
        .in_valid(in_valid), .in_ready(in_ready), .in_timestamp(in_timestamp), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .clear_errors(clear_errors),
        .overflow_error(overflow_error), .late_error(late_error),
        .late_count(late_count), .fifo_count(fifo_count)
    );

    // One clock: record handshakes, rises (with the counter the DUT saw) and stall violations.
    task automatic tick();
        logic vb, hs;
        logic [127:0] db;
        vb = out_valid;
        hs = out_valid && out_ready;
        db = out_data;
        @(posedge clk);
        #1;
        if (hs) acc_q.push_back(db);
        if (!vb && out_valid) rise_q.push_back(counter);
        if (vb && !hs && (!out_valid || out_data !== db)) stall_break++;
        if (cnt_en) counter = counter + 64'd1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clr_mon();
        acc_q.delete();
        rise_q.delete();
        stall_break = 0;
    endtask

    task automatic clr_err();
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
    endtask

    task automatic put(input logic [63:0] ts, input logic [63:0] tag);
        in_valid = 1'b1;
        in_timestamp = ts;
        in_data = {ts, tag};
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
        checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL reset_out_data: got %0h exp 0", out_data); end
        ticks(3);
        checks++; if (overflow_error !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b exp 0", overflow_error); end
        checks++; if (late_error !== 1'b0) begin errors++; $display("FAIL reset_late: got %0b exp 0", late_error); end
        checks++; if (late_count !== 16'd0) begin errors++; $display("FAIL reset_late_count: got %0d exp 0", late_count); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d exp 0", fifo_count); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [63:0] tag;
        int guard;
        clr_mon();
        tag = {$urandom, $urandom};
        counter = 64'd100;
        cnt_en = 1'b1;
        out_ready = 1'b1;
        put(64'd110, tag);
        guard = 0;
        while (acc_q.size() == 0 && guard < 40) begin tick(); guard++; end
        ticks(5);
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d exp 1", acc_q.size()); end
        if (acc_q.size() >= 1) begin
            checks++; if (acc_q[0] !== {64'd110, tag}) begin errors++; $display("FAIL single_data: got %0h exp %0h", acc_q[0], {64'd110, tag}); end
        end
        if (rise_q.size() >= 1) begin
            checks++; if (rise_q[0] !== 64'd110) begin errors++; $display("FAIL single_timing: rose after counter %0d exp 110", rise_q[0]); end
        end
        checks++; if (late_error !== 1'b0) begin errors++; $display("FAIL single_late: got %0b exp 0", late_error); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] tags [3];
        int guard;
        clr_mon();
        counter = 64'd195;
        cnt_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tags[i] = {32'd0, $urandom};
            put(64'd200 + 64'(2 * i), tags[i]);
        end
        guard = 0;
        while (acc_q.size() < 3 && guard < 40) begin tick(); guard++; end
        ticks(3);
        checks++; if (acc_q.size() != 3 || rise_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d/%0d exp 3", acc_q.size(), rise_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < acc_q.size() && i < rise_q.size()) begin
                checks++;
                if (acc_q[i] !== {64'd200 + 64'(2 * i), tags[i]} || rise_q[i] !== 64'd200 + 64'(2 * i)) begin
                    errors++; $display("FAIL b2b_event%0d: got data %0h at %0d exp ts %0d", i, acc_q[i], rise_q[i], 200 + 2 * i);
                end
            end
        end
        checks++; if (late_error !== 1'b0) begin errors++; $display("FAIL b2b_late: got %0b exp 0", late_error); end
    endtask

    task automatic test_late();
        clr_mon();
        counter = 64'd500;
        cnt_en = 1'b1;
        put(64'd300, 64'h1234);
        ticks(5);
        checks++; if (late_error !== 1'b1) begin errors++; $display("FAIL late_flag: got %0b exp 1", late_error); end
        checks++; if (late_count !== 16'd1) begin errors++; $display("FAIL late_count: got %0d exp 1", late_count); end
        checks++; if (rise_q.size() != 0) begin errors++; $display("FAIL late_no_issue: got %0d rises exp 0", rise_q.size()); end
        clr_err();
        checks++; if ({overflow_error, late_error, late_count} !== 18'd0) begin
            errors++; $display("FAIL clear_errors: got ovf %0b late %0b cnt %0d exp all 0", overflow_error, late_error, late_count);
        end
    endtask

    // Events are written with the counter frozen; pasts are dropped, futures issue in order.
    task automatic test_random_stream();
        logic [63:0] exp_ts[$];
        logic [127:0] exp_d[$];
        logic [63:0] c, nxt, ts, tag, last;
        int npast, pend, guard;
        for (int it = 0; it < 3; it++) begin
            clr_err();
            clr_mon();
            exp_ts.delete();
            exp_d.delete();
            cnt_en = 1'b0;
            c = 64'd1000 + 64'($urandom_range(0, 50000));
            counter = c;
            nxt = c + 64'd12;
            last = c;
            npast = 0;
            pend = 0;
            for (int e = 0; e < 8; e++) begin
                tag = {32'd0, $urandom};
                if ($urandom_range(0, 2) == 0) begin
                    ts = c - 64'($urandom_range(1, 500));
                    npast++;
                    pend++;
                end else begin
                    ts = nxt;
                    exp_ts.push_back(ts);
                    exp_d.push_back({ts, tag});
                    last = ts;
                    nxt = ts + 64'(3 + pend + $urandom_range(0, 4));
                    pend = 0;
                end
                put(ts, tag);
            end
            cnt_en = 1'b1;
            guard = 0;
            while (counter <= last + 64'd8 && guard < 400) begin tick(); guard++; end
            checks++; if (acc_q.size() != exp_d.size()) begin errors++; $display("FAIL stream%0d_count: got %0d exp %0d", it, acc_q.size(), exp_d.size()); end
            for (int i = 0; i < exp_d.size(); i++) begin
                if (i < acc_q.size() && i < rise_q.size()) begin
                    checks++;
                    if (acc_q[i] !== exp_d[i] || rise_q[i] !== exp_ts[i]) begin
                        errors++; $display("FAIL stream%0d_event%0d: got %0h at %0d exp %0h at %0d", it, i, acc_q[i], rise_q[i], exp_d[i], exp_ts[i]);
                    end
                end
            end
            checks++; if (late_count !== 16'(npast)) begin errors++; $display("FAIL stream%0d_late_count: got %0d exp %0d", it, late_count, npast); end
            checks++; if (late_error !== (npast != 0)) begin errors++; $display("FAIL stream%0d_late_flag: got %0b exp %0b", it, late_error, npast != 0); end
            checks++; if (stall_break != 0) begin errors++; $display("FAIL stream%0d_stable: got %0d breaks exp 0", it, stall_break); end
        end
    endtask

    task automatic test_overflow();
        clr_err();
        clr_mon();
        cnt_en = 1'b0;
        counter = 64'd10;
        for (int i = 0; i <= DEPTH; i++) put(64'd1000000 + 64'(i), 64'(i));
        ticks(2);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready: got %0b exp 0", in_ready); end
        checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL ovf_fill_count: got %0d exp %0d", fifo_count, DEPTH); end
        checks++; if (overflow_error !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b exp 0", overflow_error); end
        put(64'd2000000, 64'd99);
        tick();
        checks++; if (overflow_error !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b exp 1", overflow_error); end
        checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL ovf_count_kept: got %0d exp %0d", fifo_count, DEPTH); end
        clr_err();
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++; if (overflow_error !== 1'b0) begin errors++; $display("FAIL flush_write_flagged: got %0b exp 0", overflow_error); end
        checks++; if (fifo_count !== 5'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty: got count %0d ready %0b exp 0/1", fifo_count, in_ready); end
    endtask

    task automatic test_stall();
        logic [63:0] ta, tb;
        int guard;
        clr_err();
        clr_mon();
        ta = {32'd0, $urandom};
        tb = {32'd0, $urandom};
        counter = 64'd40;
        cnt_en = 1'b1;
        out_ready = 1'b0;
        put(64'd50, ta);
        put(64'd52, tb);
        guard = 0;
        while (counter != 64'd60 && guard < 40) begin tick(); guard++; end
        checks++; if (out_valid !== 1'b1 || out_data !== {64'd50, ta}) begin
            errors++; $display("FAIL stall_hold: got valid %0b data %0h exp 1 %0h", out_valid, out_data, {64'd50, ta});
        end
        out_ready = 1'b1;
        ticks(6);
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL stall_count: got %0d exp 1", acc_q.size()); end
        if (acc_q.size() >= 1) begin
            checks++; if (acc_q[0] !== {64'd50, ta}) begin errors++; $display("FAIL stall_data: got %0h exp %0h", acc_q[0], {64'd50, ta}); end
        end
        if (rise_q.size() >= 1) begin
            checks++; if (rise_q[0] !== 64'd50) begin errors++; $display("FAIL stall_timing: got %0d exp 50", rise_q[0]); end
        end
        checks++; if (late_count !== 16'd1 || late_error !== 1'b1) begin errors++; $display("FAIL stall_late: got cnt %0d flag %0b exp 1/1", late_count, late_error); end
        checks++; if (stall_break != 0) begin errors++; $display("FAIL stall_stable: got %0d breaks exp 0", stall_break); end
    endtask

    task automatic test_flush_reset();
        int guard;
        clr_err();
        clr_mon();
        cnt_en = 1'b0;
        counter = 64'd1000;
        put(64'd10, 64'd1);
        for (int i = 0; i < 4; i++) put(64'd1020 + 64'(i), 64'(i));
        ticks(3);
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL flush_pre_count: got %0d exp 3", fifo_count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (fifo_count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got count %0d valid %0b exp 0/0", fifo_count, out_valid); end
        checks++; if (late_error !== 1'b1 || late_count !== 16'd1) begin errors++; $display("FAIL flush_keeps_errors: got %0b/%0d exp 1/1", late_error, late_count); end
        cnt_en = 1'b1;
        ticks(40);
        checks++; if (rise_q.size() != 0) begin errors++; $display("FAIL flush_no_issue: got %0d rises exp 0", rise_q.size()); end
        put(counter + 64'd5, 64'hABCD);
        ticks(12);
        checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL flush_then_issue: got %0d exp 1", acc_q.size()); end
        // Reset in the middle of an ISSUE stall with more events queued.
        out_ready = 1'b0;
        put(counter + 64'd4, 64'd7);
        put(counter + 64'd100, 64'd8);
        put(counter + 64'd200, 64'd9);
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin tick(); guard++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_issue_reached: got %0b exp 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || fifo_count !== 5'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_issue: got valid %0b count %0d ready %0b exp 0/0/1", out_valid, fifo_count, in_ready);
        end
        checks++; if (late_error !== 1'b0 || late_count !== 16'd0) begin errors++; $display("FAIL reset_clears_errors: got %0b/%0d exp 0/0", late_error, late_count); end
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        ticks(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_late();
        test_random_stream();
        test_overflow();
        test_stall();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
